// File: rtl/keypad_display_pkg.sv
// Shared constants and types for the keypad display output path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package keypad_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [3:0] DEFAULT_CLR_CODE = 4'hA;
  localparam logic [3:0] DEFAULT_BSP_CODE = 4'hB;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_DIGIT,
    ACT_CLEAR,
    ACT_BACK
  } key_action_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex to active-low 7-segment decoder with a blanking input.
// Shared by the output-side display blocks.
module hex_to_7seg
  import keypad_display_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      unique case (i_code)
        4'h0: o_seg = SEG_DIGIT[0];
        4'h1: o_seg = SEG_DIGIT[1];
        4'h2: o_seg = SEG_DIGIT[2];
        4'h3: o_seg = SEG_DIGIT[3];
        4'h4: o_seg = SEG_DIGIT[4];
        4'h5: o_seg = SEG_DIGIT[5];
        4'h6: o_seg = SEG_DIGIT[6];
        4'h7: o_seg = SEG_DIGIT[7];
        4'h8: o_seg = SEG_DIGIT[8];
        4'h9: o_seg = SEG_DIGIT[9];
        4'hA: o_seg = 7'h08;
        4'hB: o_seg = 7'h03;
        4'hC: o_seg = 7'h46;
        4'hD: o_seg = 7'h21;
        4'hE: o_seg = 7'h06;
        4'hF: o_seg = 7'h0E;
      endcase
    end
  end

endmodule

// File: rtl/keypad_display_sink.sv
// Assembles encoder keystrokes into a BCD entry buffer and scans it onto a
// common-anode 7-segment display. Define DAV_SYNC_EN to synchronise dav.
module keypad_display_sink
  import keypad_display_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter logic [3:0]  CLR_CODE = DEFAULT_CLR_CODE,
  parameter logic [3:0]  BSP_CODE = DEFAULT_BSP_CODE
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         scan_tick,
  input  logic [3:0]                   KeypadData,
  input  logic                         dav,
  output logic [4*DIGITS-1:0]          value,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic [DIGITS-1:0]            an,
  output logic [6:0]                   seg
);

  localparam int unsigned      CW        = $clog2(DIGITS + 1);
  localparam int unsigned      IW        = $clog2(DIGITS);
  localparam logic [CW-1:0]    COUNT_MAX = CW'(DIGITS);
  localparam logic [CW-1:0]    COUNT_ONE = CW'(1);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [IW-1:0]    IDX_ONE   = IW'(1);
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

  logic w_dav;
  logic r_dav_prev;
  logic w_event;

`ifdef DAV_SYNC_EN
  // Encoder runs on a divider-generated clock, so dav needs two flops first.
  logic r_dav_s1;
  logic r_dav_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dav_s1 <= 1'b0;
      r_dav_s2 <= 1'b0;
    end else begin
      r_dav_s1 <= dav;
      r_dav_s2 <= r_dav_s1;
    end
  end

  assign w_dav = r_dav_s2;
`else
  assign w_dav = dav;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dav_prev <= 1'b0;
    end else begin
      r_dav_prev <= w_dav;
    end
  end

  assign w_event = w_dav & ~r_dav_prev;

  key_action_t w_action;

  always_comb begin
    w_action = ACT_NONE;
    if (w_event) begin
      if (KeypadData <= 4'd9) begin
        w_action = ACT_DIGIT;
      end else if (KeypadData == CLR_CODE) begin
        w_action = ACT_CLEAR;
      end else if (KeypadData == BSP_CODE) begin
        w_action = ACT_BACK;
      end
    end
  end

  logic [4*DIGITS-1:0] r_value;
  logic [CW-1:0]       r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_value <= '0;
      r_count <= '0;
    end else begin
      unique case (w_action)
        ACT_DIGIT: begin
          r_value <= {r_value[4*DIGITS-5:0], KeypadData};
          if (r_count != COUNT_MAX) begin
            r_count <= r_count + COUNT_ONE;
          end
        end
        ACT_CLEAR: begin
          r_value <= '0;
          r_count <= '0;
        end
        ACT_BACK: begin
          if (r_count != '0) begin
            r_value <= {4'h0, r_value[4*DIGITS-1:4]};
            r_count <= r_count - COUNT_ONE;
          end
        end
        ACT_NONE: begin
        end
      endcase
    end
  end

  logic [IW-1:0]     r_idx;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;
  logic [3:0]        w_nibble;
  logic              w_blank;
  logic [6:0]        w_seg;

  // Scan reads the pre-update buffer when a key event lands on the same edge.
  assign w_nibble = r_value[4*r_idx +: 4];
  assign w_blank  = (CW'(r_idx) >= r_count);

  hex_to_7seg u_hex_to_7seg (
    .i_code  (w_nibble),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx <= '0;
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else if (scan_tick) begin
      r_an  <= ~(AN_ONE << r_idx);
      r_seg <= w_seg;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_ONE;
    end
  end

  assign value = r_value;
  assign count = r_count;
  assign an    = r_an;
  assign seg   = r_seg;

endmodule

// File: tb/tb_keypad_display_sink.sv
// Scoreboard bench for keypad_display_sink: stimulus pushes expectations from an
// arithmetic model, monitors pop them when the DUT updates. Honours DAV_SYNC_EN.
module tb_keypad_display_sink;

`ifdef DAV_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        scan_tick;
  logic [3:0]  KeypadData;
  logic        dav;
  logic [15:0] value;
  logic [2:0]  count;
  logic [3:0]  an;
  logic [6:0]  seg;

  keypad_display_sink dut (
    .clock      (clock),
    .reset      (reset),
    .scan_tick  (scan_tick),
    .KeypadData (KeypadData),
    .dav        (dav),
    .value      (value),
    .count      (count),
    .an         (an),
    .seg        (seg)
  );

  always #5 clock = ~clock;

  typedef struct {
    int bv;
    int bc;
    int av;
    int ac;
  } bexp_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } sexp_t;

  bexp_t bq[$];
  sexp_t sq[$];

  int n_checks = 0;
  int n_err    = 0;

  logic [6:0] segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model: buffer as an integer of nibbles plus a digit count.
  int m_val = 0;
  int m_cnt = 0;
  int m_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_key(input int code);
    if (code <= 9) begin
      m_val = ((m_val << 4) | code) & 16'hFFFF;
      if (m_cnt < 4) m_cnt++;
    end else if (code == 10) begin
      m_val = 0;
      m_cnt = 0;
    end else if (code == 11 && m_cnt > 0) begin
      m_val = m_val >> 4;
      m_cnt--;
    end
  endtask

  task automatic push_tick(input int val, input int cnt);
    sexp_t s;
    int nib;
    s.an = 4'hF;
    s.an[m_idx] = 1'b0;
    nib = (val >> (4 * m_idx)) & 15;
    s.seg = (m_idx < cnt && nib <= 9) ? segs[nib] : 7'h7F;
    sq.push_back(s);
    m_idx = (m_idx + 1) % 4;
  endtask

  task automatic idle(input int n, input bit force_tick);
    for (int c = 0; c < n; c++) begin
      bit t;
      t = force_tick ? 1'b1 : ($urandom_range(0, 3) == 0);
      @(negedge clock);
      dav = 1'b0;
      scan_tick = t;
      if (t) push_tick(m_val, m_cnt);
    end
    @(negedge clock);
    scan_tick = 1'b0;
  endtask

  task automatic press(input int code, input int hold, input bit tick_commit);
    bexp_t e;
    e.bv = m_val;
    e.bc = m_cnt;
    model_key(code);
    e.av = m_val;
    e.ac = m_cnt;
    bq.push_back(e);
    for (int c = 0; c < hold; c++) begin
      bit t;
      t = (c == LAT - 1) ? tick_commit : ($urandom_range(0, 3) == 0);
      @(negedge clock);
      if (c == 0) begin
        KeypadData = 4'(code);
        dav = 1'b1;
      end
      scan_tick = t;
      if (t) push_tick(c < LAT ? e.bv : e.av, c < LAT ? e.bc : e.ac);
    end
    @(negedge clock);
    dav = 1'b0;
    scan_tick = 1'b0;
    idle(2, 1'b0);
  endtask

  // Buffer monitor: checks old value until the commit edge, new value after,
  // and that a long dav level does not produce a second entry.
  initial begin
    bexp_t e;
    int n;
    forever begin
      @(posedge dav);
      if (bq.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL buf_queue: got empty expected entry at %0t", $time);
      end else begin
        e = bq.pop_front();
        repeat (LAT - 1) @(posedge clock);
        #1;
        chk("pre_value", value, e.bv);
        chk("pre_count", count, e.bc);
        @(posedge clock);
        #1;
        chk("value", value, e.av);
        chk("count", count, e.ac);
        n = 0;
        while (dav && n < 1000) begin
          @(posedge clock);
          n++;
        end
        #1;
        chk("dav_release", dav, 0);
        chk("hold_value", value, e.av);
      end
    end
  end

  // Scan monitor: every sampled tick must present the next expected digit.
  always @(posedge clock) begin
    if (scan_tick && !reset) begin
      sexp_t s;
      #1;
      if (sq.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL scan_queue: got empty expected entry at %0t", $time);
      end else begin
        s = sq.pop_front();
        chk("an", an, s.an);
        chk("seg", seg, s.seg);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: got no finish expected finish by 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    dav = 1'b0;
    scan_tick = 1'b0;
    KeypadData = 4'h0;
    repeat (3) @(negedge clock);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_value", value, 16'h0000);
    chk("rst_count", count, 0);
    reset = 1'b0;
    idle(2, 1'b0);

    press(1, 5, 0);
    press(2, 5, 0);
    press(3, 5, 0);
    chk("tp_0123", value, 16'h0123);
    idle(4, 1'b1);

    press(10, 5, 0);
    for (int k = 1; k <= 5; k++) press(k, 5, 0);
    chk("tp_2345", value, 16'h2345);
    chk("tp_full", count, 4);
    press(13, 5, 0);
    chk("tp_ignore", value, 16'h2345);

    press(10, 5, 0);
    press(7, 5, 0);
    press(8, 5, 0);
    press(11, 5, 0);
    chk("tp_bsp", value, 16'h0007);
    press(11, 5, 0);
    press(11, 5, 0);
    chk("tp_underflow", count, 0);

    press(9, 5, 0);
    press(9, 5, 0);
    press(10, 5, 0);
    idle(4, 1'b1);

    press(5, 200, 0);
    chk("tp_hold", value, 16'h0005);

    // dav edge while reset is asserted must not enter a digit.
    @(negedge clock);
    reset = 1'b1;
    scan_tick = 1'b0;
    begin
      bexp_t e;
      e.bv = 0; e.bc = 0; e.av = 0; e.ac = 0;
      bq.push_back(e);
    end
    m_val = 0;
    m_cnt = 0;
    m_idx = 0;
    @(negedge clock);
    KeypadData = 4'h5;
    dav = 1'b1;
    @(negedge clock);
    dav = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    chk("rst_dav_an", an, 4'hF);
    idle(2, 1'b0);

    press(6, 5, 1);
    press(4, 6, 1);
    idle(4, 1'b1);

    for (int r = 0; r < 80; r++) begin
      int code;
      code = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 9) : $urandom_range(10, 15);
      press(code, $urandom_range(LAT + 1, 8), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3), 1'b0);
    end

    idle(8, 1'b0);
    chk("buf_drained", bq.size(), 0);
    chk("scan_drained", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_display_sink.md
Name: keypad_display_sink

Overview:
Output-side counterpart to the keypad encoder. Consumes the encoder's KeypadData/dav handshake and assembles keystrokes into a DIGITS-wide BCD entry buffer. Handles clear and backspace keys. Drives a time-multiplexed common-anode 7-segment display by scanning digits, the output analogue of the keypad row scan. Sits in the Saida (output) top, fed from Entrada.

Parameters:
DIGITS, 4, number of display digits and buffer nibbles (2..8)
CLR_CODE, 4'hA, key code that clears the buffer ('*')
BSP_CODE, 4'hB, key code that deletes the last digit ('#')

Ports:
clock  in  1  system clock (50 MHz); sole clock
reset  in  1  synchronous, active-high reset
scan_tick  in  1  one-cycle scan enable (from 500 Hz divider strobe)
KeypadData  in  4  key code from the encoder; valid while dav high
dav  in  1  data-available from the encoder; level, held while key pressed
value  out  4*DIGITS  entry buffer; nibble 0 is the most recently entered digit
count  out  $clog2(DIGITS+1)  number of valid digits (0..DIGITS)
an  out  DIGITS  digit enables, active-low, one-hot while scanning
seg  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset: value=0, count=0, an=all 1s, seg=7'h7F, scan index=0, dav history=0. Reset wins over every simultaneous event.
- Key event: rising edge of the (optionally synchronised) dav. Exactly one event per dav high period, however long the level is held.
- KeypadData is sampled in the cycle the event is detected. The buffer/count update is visible on the next edge.
- Codes 0x0–0x9:
  - value <= {value[4*DIGITS-5:0], code}.
  - count <= min(count+1, DIGITS).
  - When full, the oldest digit falls off the top and count stays at DIGITS.
- CLR_CODE: value<=0, count<=0.
- BSP_CODE: value <= value>>4 and count<=count-1. Ignored when count==0.
- All other codes (0xC–0xF): ignored, no state change.
- Scan:
  - On each scan_tick: an <= ~(1<<idx), seg <= pattern for digit idx, then idx <= (idx==DIGITS-1) ? 0 : idx+1.
  - an/seg hold between ticks. The first tick after reset drives digit 0.
- Pattern rules:
  - Digit i with i>=count is blank (7'h7F); otherwise the hex-to-7seg of nibble i.
  - Active-low values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Simultaneous key event and scan_tick: both take effect. The tick uses the pre-update buffer, so the new digit appears on the next visit.

Optional Feature:
DAV_SYNC_EN:
- Defined: dav passes through a 2-flop synchroniser before edge detection, because the encoder runs on a divider-generated clock. The buffer updates 3 edges after dav is first sampled high.
- Undefined: dav feeds edge detection directly. Latency is 1 edge. Use only when the encoder shares clock.
- KeypadData is never synchronised; it is stable while dav is high.

Decomposition:
- Package keypad_display_pkg:
  - SEG_BLANK, SEG_DIGIT[0:9] active-low constants.
  - CLR_CODE/BSP_CODE default localparams.
  - key_action_t enum {ACT_NONE, ACT_DIGIT, ACT_CLEAR, ACT_BACK}.
- Sub-module hex_to_7seg: combinational, 4-bit code plus blank flag in, 7-bit active-low segments out. Shared with other output blocks.

Test Plan:
- Reset asserted 3 cycles -> an=4'b1111, seg=7'h7F, value=16'h0000, count=0.
- dav pulses with codes 1,2,3, then 4 scan_ticks -> value=16'h0123, count=3; seg sequence 30,24,79,7F with an 1110,1101,1011,0111.
- Codes 1,2,3,4,5 -> value=16'h2345, count=4; code 0xD afterwards -> unchanged.
- Codes 7,8 then BSP (0xB) -> value=16'h0007, count=1; two more BSP -> value=0, count=0, no underflow.
- Codes 9,9 then CLR (0xA) -> value=0, count=0; next 4 ticks give seg=7F on all digits.
- dav held high 200 cycles with code 5 -> single entry, value=16'h0005. dav edge coincident with reset -> value=0. dav edge coincident with scan_tick -> both occur. Run with and without DAV_SYNC_EN, checking latency 3 vs 1.
